// File: rtl/axi_burst_splitter_if.sv
// Request/descriptor bundle between the address generator and the burst splitter.
// The master side issues requests and consumes descriptors; the slave side is the splitter.
interface axi_burst_splitter_if #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int LEN_W      = 20
);
    localparam int BYTES = AXI_DATA_W / 8;

    logic                  start;
    logic [AXI_ADDR_W-1:0] start_addr;
    logic [LEN_W-1:0]      length;
    logic                  busy;
    logic                  done;
    logic                  burst_valid;
    logic                  burst_ready;
    logic [AXI_ADDR_W-1:0] burst_addr;
    logic [7:0]            burst_axlen;
    logic [2:0]            burst_axsize;
    logic [BYTES-1:0]      burst_first_strb;
    logic [BYTES-1:0]      burst_last_strb;
    logic                  burst_last;

    modport master (
        output start, start_addr, length, burst_ready,
        input  busy, done, burst_valid, burst_addr, burst_axlen, burst_axsize,
               burst_first_strb, burst_last_strb, burst_last
    );

    modport slave (
        input  start, start_addr, length, burst_ready,
        output busy, done, burst_valid, burst_addr, burst_axlen, burst_axsize,
               burst_first_strb, burst_last_strb, burst_last
    );
endinterface

// File: rtl/axi_burst_splitter.sv
// Splits a byte-granular transfer into AXI burst descriptors that never cross a
// 4 KB boundary or exceed MAX_BURST_LEN beats, with first/last-beat byte strobes.
module axi_burst_splitter #(
    parameter int AXI_ADDR_W    = 32,
    parameter int AXI_DATA_W    = 32,
    parameter int LEN_W         = 20,
    parameter int MAX_BURST_LEN = 256
) (
    input logic                  clk,
    input logic                  rst,
    axi_burst_splitter_if.slave  req_if
);
    localparam int BYTES  = AXI_DATA_W / 8;
    localparam int OFF_SH = $clog2(BYTES);
    localparam int SW     = OFF_SH + 1;
    localparam int CW     = (LEN_W + 1 > 13) ? LEN_W + 1 : 13;
    localparam int SUM_W  = CW + 1;
    localparam int AW     = AXI_ADDR_W;
    localparam logic [BYTES-1:0] ONES     = '1;
    localparam logic [AW-1:0]    OFF_MASK = AW'(BYTES - 1);

    // state     | meaning
    // S_IDLE    | waiting for start
    // S_COMPUTE | register the next descriptor, advance cur/remaining
    // S_ISSUE   | descriptor valid, waiting for ready
    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_ISSUE} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cur_q, cur_d;
    logic [CW-1:0]     rem_q, rem_d;
    logic [SW-1:0]     off_q, off_d;
    logic [SW-1:0]     end_off_q, end_off_d;
    logic              first_q, first_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [7:0]        axlen_q, axlen_d;
    logic [BYTES-1:0]  fstrb_q, fstrb_d;
    logic [BYTES-1:0]  lstrb_q, lstrb_d;
    logic              last_q, last_d;
    logic              done_q, done_d;

    logic [SW-1:0]     off_in;
    logic [SUM_W-1:0]  sum;
    logic [CW-1:0]     total_beats;
    logic [SW-1:0]     end_off_in;
    logic [CW-1:0]     to4k;
    logic [CW-1:0]     beats_cap;
    logic [CW-1:0]     beats;
    logic              is_last;

    assign off_in      = SW'(req_if.start_addr & OFF_MASK);
    assign sum         = SUM_W'(off_in) + SUM_W'(req_if.length);
    assign total_beats = CW'((sum + SUM_W'(BYTES - 1)) >> OFF_SH);
    assign end_off_in  = SW'(sum & SUM_W'(BYTES - 1));

    // cur is always beat-aligned, so the distance to the next 4 KB page divides exactly
    assign to4k      = CW'((13'd4096 - {1'b0, cur_q[11:0]}) >> OFF_SH);
    assign beats_cap = (rem_q < CW'(MAX_BURST_LEN)) ? rem_q : CW'(MAX_BURST_LEN);
    assign beats     = (beats_cap < to4k) ? beats_cap : to4k;
    assign is_last   = (beats == rem_q);

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        rem_d     = rem_q;
        off_d     = off_q;
        end_off_d = end_off_q;
        first_d   = first_q;
        addr_d    = addr_q;
        axlen_d   = axlen_q;
        fstrb_d   = fstrb_q;
        lstrb_d   = lstrb_q;
        last_d    = last_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_if.start) begin
                    if (req_if.length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        cur_d     = req_if.start_addr & ~OFF_MASK;
                        rem_d     = total_beats;
                        off_d     = off_in;
                        end_off_d = end_off_in;
                        first_d   = 1'b1;
                        state_d   = S_COMPUTE;
                    end
                end
            end
            S_COMPUTE: begin
                addr_d  = cur_q;
                axlen_d = 8'(beats - CW'(1));
                fstrb_d = first_q ? (ONES << off_q) : ONES;
                last_d  = is_last;
                lstrb_d = (is_last && end_off_q != '0) ? (ONES >> (SW'(BYTES) - end_off_q)) : ONES;
                cur_d   = cur_q + (AW'(beats) << OFF_SH);
                rem_d   = rem_q - beats;
                first_d = 1'b0;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (req_if.burst_ready) begin
                    if (rem_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_COMPUTE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cur_q     <= '0;
            rem_q     <= '0;
            off_q     <= '0;
            end_off_q <= '0;
            first_q   <= 1'b0;
            addr_q    <= '0;
            axlen_q   <= '0;
            fstrb_q   <= '0;
            lstrb_q   <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            rem_q     <= rem_d;
            off_q     <= off_d;
            end_off_q <= end_off_d;
            first_q   <= first_d;
            addr_q    <= addr_d;
            axlen_q   <= axlen_d;
            fstrb_q   <= fstrb_d;
            lstrb_q   <= lstrb_d;
            last_q    <= last_d;
            done_q    <= done_d;
        end
    end

    assign req_if.busy             = (state_q != S_IDLE);
    assign req_if.done             = done_q;
    assign req_if.burst_valid      = (state_q == S_ISSUE);
    assign req_if.burst_addr       = addr_q;
    assign req_if.burst_axlen      = axlen_q;
    assign req_if.burst_axsize     = 3'(OFF_SH);
    assign req_if.burst_first_strb = fstrb_q;
    assign req_if.burst_last_strb  = lstrb_q;
    assign req_if.burst_last       = last_q;
endmodule

// File: tb/tb_axi_burst_splitter.sv
// Bench for axi_burst_splitter: table of directed requests, hand-written corner
// sequences, and random requests checked against a byte-range reference model.
module tb_axi_burst_splitter;
    localparam int BY = 4;

    typedef struct packed {
        logic [31:0]   addr;
        logic [7:0]    axlen;
        logic [BY-1:0] fs;
        logic [BY-1:0] ls;
        logic          last;
    } desc_t;

    typedef struct {
        logic [31:0] sa;
        logic [19:0] len;
        int          cnt;
        desc_t       d0;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    desc_t exp_q[$];

    always #5 clk = ~clk;

    axi_burst_splitter_if #(.AXI_ADDR_W(32), .AXI_DATA_W(32), .LEN_W(20)) bus ();
    axi_burst_splitter_if #(.AXI_ADDR_W(32), .AXI_DATA_W(32), .LEN_W(20)) bus16 ();

    axi_burst_splitter #(.AXI_ADDR_W(32), .AXI_DATA_W(32), .LEN_W(20), .MAX_BURST_LEN(256))
        dut (.clk(clk), .rst(rst), .req_if(bus));
    axi_burst_splitter #(.AXI_ADDR_W(32), .AXI_DATA_W(32), .LEN_W(20), .MAX_BURST_LEN(16))
        dut16 (.clk(clk), .rst(rst), .req_if(bus16));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    function automatic desc_t sample();
        desc_t d;
        d.addr  = bus.burst_addr;
        d.axlen = bus.burst_axlen;
        d.fs    = bus.burst_first_strb;
        d.ls    = bus.burst_last_strb;
        d.last  = bus.burst_last;
        return d;
    endfunction

    // Model: walk the byte range [sa, sa+len) beat-aligned; each burst ends at the
    // nearest of the beat cap, the next 4 KB page, or the beat holding the last byte.
    function automatic void build_model(input logic [31:0] sa, input int unsigned len,
                                        input int unsigned maxb);
        longint first_b, last_b, cur, e, lim, b4k, dend;
        desc_t d;
        bit first;
        exp_q.delete();
        first_b = longint'(sa);
        last_b  = first_b + longint'(len) - 1;
        cur     = (first_b / BY) * BY;
        dend    = (last_b / BY + 1) * BY;
        first   = 1'b1;
        while (cur <= last_b) begin
            lim = cur + longint'(maxb) * BY;
            b4k = (cur / 4096 + 1) * 4096;
            e   = lim;
            if (b4k < e) e = b4k;
            if (dend < e) e = dend;
            d.addr  = cur[31:0];
            d.axlen = 8'((e - cur) / BY - 1);
            d.last  = (e == dend);
            for (int j = 0; j < BY; j++) begin
                d.fs[j] = !first || (cur + j >= first_b);
                d.ls[j] = !d.last || (e - BY + j <= last_b);
            end
            exp_q.push_back(d);
            cur   = e;
            first = 1'b0;
        end
    endfunction

    task automatic cmp_desc(input string nm, input desc_t act, input desc_t exp);
        chk({nm, "_addr"}, act.addr, exp.addr);
        chk({nm, "_axlen"}, act.axlen, exp.axlen);
        chk({nm, "_fstrb"}, act.fs, exp.fs);
        chk({nm, "_lstrb"}, act.ls, exp.ls);
        chk({nm, "_last"}, act.last, exp.last);
    endtask

    task automatic run_req(input logic [31:0] sa, input logic [19:0] len, input int ready_pct,
                           output int cnt, output desc_t first_d);
        desc_t cur, snap;
        bit held, prev_hs, rdy;
        int budget;
        build_model(sa, int'(len), 256);
        cnt = 0;
        first_d = '0;
        snap = '0;
        @(negedge clk);
        bus.start_addr = sa;
        bus.length = len;
        bus.start = 1'b1;
        bus.burst_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("lat_compute_valid", bus.burst_valid, 0);
        chk("lat_busy", bus.busy, 1);
        @(negedge clk);
        chk("lat_issue_valid", bus.burst_valid, 1);
        held = 0;
        prev_hs = 0;
        budget = 0;
        while (cnt < exp_q.size() && budget < 4000) begin
            if (prev_hs) begin
                chk("bubble_valid", bus.burst_valid, 0);
                prev_hs = 0;
            end else if (bus.burst_valid) begin
                cur = sample();
                if (held) chk("hold_stable", cur, snap);
                rdy = ($urandom_range(0, 99) < ready_pct);
                bus.burst_ready = rdy;
                if (rdy) begin
                    cmp_desc($sformatf("desc%0d", cnt), cur, exp_q[cnt]);
                    if (cnt == 0) first_d = cur;
                    cnt++;
                    held = 0;
                    prev_hs = 1;
                end else begin
                    snap = cur;
                    held = 1;
                end
            end
            @(negedge clk);
            bus.burst_ready = 1'b0;
            budget++;
        end
        chk("desc_count", cnt, exp_q.size());
        chk("done_pulse", bus.done, 1);
        chk("done_busy", bus.busy, 0);
        chk("done_valid", bus.burst_valid, 0);
        @(negedge clk);
        chk("done_cleared", bus.done, 0);
    endtask

    vec_t  tbl[6];
    desc_t d0, snap;
    int    cnt, n, extra;

    initial begin
        tbl[0] = '{32'h0000_1000, 20'd16,   1, '{32'h0000_1000, 8'd3,   4'hF,    4'hF,    1'b1}};
        tbl[1] = '{32'h0000_0FF8, 20'd16,   2, '{32'h0000_0FF8, 8'd1,   4'hF,    4'hF,    1'b0}};
        tbl[2] = '{32'h0000_1003, 20'd6,    1, '{32'h0000_1000, 8'd2,   4'b1000, 4'b0001, 1'b1}};
        tbl[3] = '{32'h0000_0000, 20'd2048, 2, '{32'h0000_0000, 8'd255, 4'hF,    4'hF,    1'b0}};
        tbl[4] = '{32'h0000_0002, 20'd1,    1, '{32'h0000_0000, 8'd0,   4'b1100, 4'b0111, 1'b1}};
        tbl[5] = '{32'h0000_0FFE, 20'd4,    2, '{32'h0000_0FFC, 8'd0,   4'b1100, 4'hF,    1'b0}};

        bus.start = 0; bus.start_addr = '0; bus.length = '0; bus.burst_ready = 0;
        bus16.start = 0; bus16.start_addr = '0; bus16.length = '0; bus16.burst_ready = 1;
        rst = 1;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_valid", bus.burst_valid, 0);
        chk("rst_addr", bus.burst_addr, 0);
        chk("rst_axlen", bus.burst_axlen, 0);
        chk("rst_fstrb", bus.burst_first_strb, 0);
        chk("rst_lstrb", bus.burst_last_strb, 0);
        chk("rst_last", bus.burst_last, 0);
        chk("axsize", bus.burst_axsize, 2);
        rst = 0;

        for (int i = 0; i < 6; i++) begin
            run_req(tbl[i].sa, tbl[i].len, 100, cnt, d0);
            chk($sformatf("tbl%0d_cnt", i), cnt, tbl[i].cnt);
            cmp_desc($sformatf("tbl%0d", i), d0, tbl[i].d0);
        end

        // MAX_BURST_LEN=16 instance: 2048 bytes -> 32 bursts of 16 beats
        @(negedge clk);
        bus16.start_addr = 32'h0; bus16.length = 20'd2048; bus16.start = 1;
        @(negedge clk);
        bus16.start = 0;
        n = 0;
        for (int b = 0; b < 500 && n < 32; b++) begin
            if (bus16.burst_valid) begin
                chk($sformatf("m16_addr%0d", n), bus16.burst_addr, n * 32'h40);
                chk($sformatf("m16_axlen%0d", n), bus16.burst_axlen, 15);
                chk($sformatf("m16_last%0d", n), bus16.burst_last, (n == 31));
                n++;
            end
            @(negedge clk);
        end
        chk("m16_count", n, 32);
        chk("m16_done", bus16.done, 1);

        // backpressure on the 4K-straddling request plus a start pulse while busy
        build_model(32'h0FF8, 16, 256);
        @(negedge clk);
        bus.start_addr = 32'h0FF8; bus.length = 20'd16; bus.start = 1; bus.burst_ready = 0;
        @(negedge clk);
        bus.start = 0;
        @(negedge clk);
        chk("bp_valid0", bus.burst_valid, 1);
        snap = sample();
        for (int k = 0; k < 5; k++) begin
            bus.start = (k == 2);
            bus.start_addr = 32'h2000; bus.length = 20'd100;
            @(negedge clk);
            bus.start = 0;
            chk($sformatf("bp_hold%0d", k), sample(), snap);
            chk($sformatf("bp_valid_hold%0d", k), bus.burst_valid, 1);
        end
        cmp_desc("bp_d0", sample(), exp_q[0]);
        bus.burst_ready = 1;
        @(negedge clk);
        bus.burst_ready = 0;
        chk("bp_bubble", bus.burst_valid, 0);
        @(negedge clk);
        chk("bp_valid1", bus.burst_valid, 1);
        cmp_desc("bp_d1", sample(), exp_q[1]);
        bus.burst_ready = 1;
        @(negedge clk);
        bus.burst_ready = 0;
        chk("bp_done", bus.done, 1);
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.burst_valid) extra++;
        end
        chk("bp_no_extra", extra, 0);

        // zero-length request
        @(negedge clk);
        bus.start_addr = 32'h1234; bus.length = 20'd0; bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        chk("zl_done", bus.done, 1);
        chk("zl_busy", bus.busy, 0);
        extra = 0;
        repeat (5) begin
            if (bus.burst_valid) extra++;
            @(negedge clk);
        end
        chk("zl_no_valid", extra, 0);
        chk("zl_done_clear", bus.done, 0);

        // reset while a descriptor is pending
        @(negedge clk);
        bus.start_addr = 32'h0; bus.length = 20'd2048; bus.start = 1; bus.burst_ready = 0;
        @(negedge clk);
        bus.start = 0;
        @(negedge clk);
        chk("ra_valid_before", bus.burst_valid, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("ra_valid", bus.burst_valid, 0);
        chk("ra_busy", bus.busy, 0);
        extra = 0;
        repeat (5) begin
            if (bus.done) extra++;
            @(negedge clk);
        end
        chk("ra_no_done", extra, 0);
        run_req(32'h0000_1003, 20'd6, 100, cnt, d0);
        chk("ra_fresh_cnt", cnt, 1);

        // random requests, some parked just below a 4K boundary
        for (int r = 0; r < 40; r++) begin
            logic [31:0] sa;
            logic [19:0] len;
            if ($urandom_range(0, 1) == 1)
                sa = (32'($urandom_range(0, 32'hFFFF)) << 12) | 32'($urandom_range(4080, 4095));
            else
                sa = 32'($urandom_range(0, 32'h0FFF_FFFF));
            if ($urandom_range(0, 7) == 0) len = 20'($urandom_range(1, 20000));
            else len = 20'($urandom_range(1, 3000));
            run_req(sa, len, 60, cnt, d0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
